ss_mult_accum_frame: RTL and testbench



---
 rtl/ss_mult_accum_frame.sv | 133 +++++++++++++
 tb/tb_ss_mult_accum_frame.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ss_mult_accum_frame.sv
// Stochastic-symbol multiply-accumulate over a frame of FRAME_LEN samples, with start/busy/done framing.
// Optional macro SS_ACC_SAT_EN: the accumulator saturates instead of wrapping.
module ss_mult_accum_frame #(
    parameter int IN_W      = 13,
    parameter int SS_W      = 5,
    parameter int FRAME_LEN = 256,
    parameter int ACC_W     = 18,
    localparam int RAND_W   = IN_W - SS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   x_input,
    input  logic [IN_W-1:0]   y_input,
    input  logic [RAND_W-1:0] x_randnum,
    input  logic [RAND_W-1:0] y_randnum,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  z_output,
    output logic              overflow
);

    localparam int PROD_W = 2 * SS_W;
    localparam int CNT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state, next_state;
    logic [SS_W-1:0]    x_sym, y_sym;
    logic               v1, v2;
    logic [PROD_W-1:0]  prod;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W:0]     sum;
    logic [CNT_W-1:0]   count;
    logic [1:0]         drain_cnt;
    logic               accept, last_sample;

    // The integer part is rounded up when the fraction beats the random number; the all-ones symbol cannot grow.
    function automatic logic [SS_W-1:0] to_sym(input logic [IN_W-1:0] v, input logic [RAND_W-1:0] r);
        logic [SS_W-1:0] hi;
        hi = v[IN_W-1:RAND_W];
        if ((v[RAND_W-1:0] > r) && (hi != '1))
            return hi + SS_W'(1);
        return hi;
    endfunction

    assign in_ready    = (state == RUN);
    assign busy        = (state != IDLE);
    assign accept      = in_valid && in_ready;
    assign last_sample = accept && (count == CNT_W'(FRAME_LEN - 1));

    always_comb begin
        sum = {1'b0, acc} + {1'b0, ACC_W'(prod)};
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Three drain cycles let the last accepted sample clear the pipeline before the result is captured.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last_sample) next_state = DRAIN;
            DRAIN:   if (drain_cnt == 2'd2) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_sym     <= '0;
            y_sym     <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            prod      <= '0;
            acc       <= '0;
            count     <= '0;
            drain_cnt <= '0;
            overflow  <= 1'b0;
            z_output  <= '0;
            done      <= 1'b0;
        end else begin
            v1 <= accept;
            if (accept) begin
                x_sym <= to_sym(x_input, x_randnum);
                y_sym <= to_sym(y_input, y_randnum);
            end
            v2 <= v1;
            if (v1)
                prod <= PROD_W'(x_sym) * PROD_W'(y_sym);

            done      <= 1'b0;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;

            if (state == IDLE && start) begin
                acc      <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                if (accept)
                    count <= count + CNT_W'(1);
                if (v2) begin
`ifdef SS_ACC_SAT_EN
                    if (sum[ACC_W]) begin
                        acc      <= '1;
                        overflow <= 1'b1;
                    end else begin
                        acc <= sum[ACC_W-1:0];
                    end
`else
                    acc <= sum[ACC_W-1:0];
                    if (sum[ACC_W])
                        overflow <= 1'b1;
`endif
                end
            end

            if (state == DRAIN && next_state == DONE) begin
                z_output <= acc;
                done     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ss_mult_accum_frame.sv
// Directed bench for ss_mult_accum_frame: four instances with different frame/accumulator sizes share one stimulus.
module tb_ss_mult_accum_frame;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [12:0] x_in, y_in;
    logic [7:0]  x_rand, y_rand;
    logic [3:0]  start_v;
    logic [3:0]  busy_v, done_v, ready_v, ovf_v;
    logic [17:0] z_def, z_f1, z_f4;
    logic [9:0]  z_a10;
    int          total = 0;
    int          bad = 0;
    int          lat;

    always #5 clk = ~clk;

    ss_mult_accum_frame u_def (
        .clk(clk), .rst(rst), .start(start_v[0]), .in_valid(in_valid), .in_ready(ready_v[0]),
        .x_input(x_in), .y_input(y_in), .x_randnum(x_rand), .y_randnum(y_rand),
        .busy(busy_v[0]), .done(done_v[0]), .z_output(z_def), .overflow(ovf_v[0])
    );

    ss_mult_accum_frame #(.FRAME_LEN(1)) u_f1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .in_valid(in_valid), .in_ready(ready_v[1]),
        .x_input(x_in), .y_input(y_in), .x_randnum(x_rand), .y_randnum(y_rand),
        .busy(busy_v[1]), .done(done_v[1]), .z_output(z_f1), .overflow(ovf_v[1])
    );

    ss_mult_accum_frame #(.FRAME_LEN(2), .ACC_W(10)) u_a10 (
        .clk(clk), .rst(rst), .start(start_v[2]), .in_valid(in_valid), .in_ready(ready_v[2]),
        .x_input(x_in), .y_input(y_in), .x_randnum(x_rand), .y_randnum(y_rand),
        .busy(busy_v[2]), .done(done_v[2]), .z_output(z_a10), .overflow(ovf_v[2])
    );

    ss_mult_accum_frame #(.FRAME_LEN(4)) u_f4 (
        .clk(clk), .rst(rst), .start(start_v[3]), .in_valid(in_valid), .in_ready(ready_v[3]),
        .x_input(x_in), .y_input(y_in), .x_randnum(x_rand), .y_randnum(y_rand),
        .busy(busy_v[3]), .done(done_v[3]), .z_output(z_f4), .overflow(ovf_v[3])
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [12:0] x, input logic [12:0] y,
                                 input logic [7:0] xr, input logic [7:0] yr);
        x_in   = x;
        y_in   = y;
        x_rand = xr;
        y_rand = yr;
    endtask

    // Pulses start at edge S and returns k where done is first seen after edge S+k (0 on timeout).
    task automatic runFrame(input int idx, input int budget, input bit toggle, input int extra_at,
                            output int latency);
        int guard;
        guard = 0;
        while (busy_v[idx] && guard < 8) begin
            tick();
            guard++;
        end
        start_v[idx] = 1'b1;
        tick();
        start_v[idx] = 1'b0;
        latency = 0;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if (done_v[idx]) begin
                latency = k;
                break;
            end
            if (toggle)
                in_valid = ~in_valid;
            start_v[idx] = (k == extra_at);
        end
        start_v[idx] = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        start_v  = '0;
        in_valid = 1'b0;
        applyStimulus(13'h0000, 13'h0000, 8'h00, 8'h00);
        tick();
        tick();
        checkOutput("rst_z",     32'(z_def),      32'd0);
        checkOutput("rst_done",  32'(done_v[0]),  32'd0);
        checkOutput("rst_ovf",   32'(ovf_v[0]),   32'd0);
        checkOutput("rst_busy",  32'(busy_v[0]),  32'd0);
        checkOutput("rst_ready", 32'(ready_v[0]), 32'd0);
        rst = 1'b0;

        // Full 256-sample frame: 10*3 per sample
        applyStimulus(13'h0A00, 13'h0300, 8'h00, 8'h00);
        in_valid = 1'b1;
        runFrame(0, 400, 1'b0, 0, lat);
        checkOutput("def_latency", 32'(lat),       32'd259);
        checkOutput("def_z",       32'(z_def),     32'd7680);
        checkOutput("def_ovf",     32'(ovf_v[0]),  32'd0);
        checkOutput("def_busy",    32'(busy_v[0]), 32'd1);
        tick();
        checkOutput("def_done_pulse", 32'(done_v[0]), 32'd0);
        checkOutput("def_idle_busy",  32'(busy_v[0]), 32'd0);
        checkOutput("def_z_hold",     32'(z_def),     32'd7680);

        // Fraction compare boundary: 0x80 > 0x7F rounds up, 0x80 > 0x80 does not
        applyStimulus(13'h0A80, 13'h0100, 8'h7F, 8'h00);
        runFrame(1, 20, 1'b0, 0, lat);
        checkOutput("f1_latency", 32'(lat),  32'd4);
        checkOutput("f1_round_up", 32'(z_f1), 32'd11);
        applyStimulus(13'h0A80, 13'h0100, 8'h80, 8'h00);
        runFrame(1, 20, 1'b0, 0, lat);
        checkOutput("f1_no_round", 32'(z_f1), 32'd10);

        // Symbol saturation at 31
        applyStimulus(13'h1FFF, 13'h1FFF, 8'h00, 8'h00);
        runFrame(1, 20, 1'b0, 0, lat);
        checkOutput("f1_sat_sym", 32'(z_f1),     32'd961);
        checkOutput("f1_sat_ovf", 32'(ovf_v[1]), 32'd0);

        // 10-bit accumulator: 961 + 961 = 1922 exceeds 1023
        applyStimulus(13'h1F00, 13'h1F00, 8'h00, 8'h00);
        runFrame(2, 20, 1'b0, 0, lat);
        checkOutput("a10_latency", 32'(lat), 32'd5);
`ifdef SS_ACC_SAT_EN
        checkOutput("a10_z", 32'(z_a10), 32'd1023);
`else
        checkOutput("a10_z", 32'(z_a10), 32'd898);
`endif
        checkOutput("a10_ovf", 32'(ovf_v[2]), 32'd1);
        tick();
        tick();
        checkOutput("a10_ovf_hold", 32'(ovf_v[2]), 32'd1);
        applyStimulus(13'h0100, 13'h0100, 8'h00, 8'h00);
        runFrame(2, 20, 1'b0, 0, lat);
        checkOutput("a10_z_next",   32'(z_a10),    32'd2);
        checkOutput("a10_ovf_clear", 32'(ovf_v[2]), 32'd0);

        // Gapped input plus an ignored start mid-frame: four samples of 2*2
        applyStimulus(13'h0200, 13'h0200, 8'h00, 8'h00);
        in_valid = 1'b1;
        runFrame(3, 40, 1'b1, 3, lat);
        checkOutput("gap_latency", 32'(lat),   32'd10);
        checkOutput("gap_z",       32'(z_f4),  32'd16);
        in_valid = 1'b1;
        tick();
        checkOutput("gap_done_pulse", 32'(done_v[3]), 32'd0);

        // Reset two samples into a frame, then a clean frame of 1*1
        tick();
        start_v[3] = 1'b1;
        tick();
        start_v[3] = 1'b0;
        tick();
        tick();
        checkOutput("mid_ready", 32'(ready_v[3]), 32'd1);
        checkOutput("mid_busy",  32'(busy_v[3]),  32'd1);
        rst = 1'b1;
        tick();
        checkOutput("mid_rst_z",     32'(z_f4),       32'd0);
        checkOutput("mid_rst_done",  32'(done_v[3]),  32'd0);
        checkOutput("mid_rst_ovf",   32'(ovf_v[3]),   32'd0);
        checkOutput("mid_rst_busy",  32'(busy_v[3]),  32'd0);
        checkOutput("mid_rst_ready", 32'(ready_v[3]), 32'd0);
        rst = 1'b0;
        applyStimulus(13'h0100, 13'h0100, 8'h00, 8'h00);
        runFrame(3, 40, 1'b0, 0, lat);
        checkOutput("fresh_latency", 32'(lat),  32'd7);
        checkOutput("fresh_z",       32'(z_f4), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
